// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one shift-and-add step per cycle, using an external
// WIDTH-bit adder driven through add_a/add_b and read back through add_y/add_cout.
module shift_add_multiplier #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    input  logic [WIDTH-1:0]   add_y,
    input  logic               add_cout
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   h_q, h_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [CntW-1:0]    count_q, count_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            m_q       <= '0;
            h_q       <= '0;
            q_q       <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            h_q       <= h_d;
            q_q       <= q_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        h_d       = h_q;
        q_d       = q_q;
        count_d   = count_q;
        product_d = product_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    m_d     = multiplicand;
                    q_d     = multiplier;
                    h_d     = '0;
                    count_d = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                // Add and shift fold into one update; the adder carry lands in the H MSB,
                // so the carry flop of {C,H,Q} is always zero after the step and is not kept.
                h_d     = {add_cout, add_y[WIDTH-1:1]};
                q_d     = {add_y[0], q_q[WIDTH-1:1]};
                count_d = count_q + 1'b1;
                if (count_q == CntW'(WIDTH - 1)) begin
                    product_d = {h_d, q_d};
                    state_d   = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        ready   = (state_q == StIdle);
        busy    = (state_q == StCalc) || (state_q == StDone);
        done    = (state_q == StDone);
        product = product_q;
        add_a   = '0;
        add_b   = '0;
        if (state_q == StCalc) begin
            add_a = h_q;
            add_b = q_q[0] ? m_q : '0;
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed cases from the test plan plus
// random operands, compared against plain integer multiplication.
module tb_shift_add_multiplier;

    localparam int unsigned W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic           ready;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic [W-1:0]   add_y;
    logic           add_cout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Stand-in for the attached 4-bit carry-ripple adder.
    assign {add_cout, add_y} = {1'b0, add_a} + {1'b0, add_b};

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .ready        (ready),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_y        (add_y),
        .add_cout     (add_cout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [2*W-1:0] prev_product = '0;

    // Called at a sample point where the DUT should be idle. Returns whether a carry-out
    // was seen on any step; with inject set, start is pulsed mid-calculation.
    task automatic run_op(input string name, input logic [W-1:0] m, input logic [W-1:0] q,
                          input bit inject, output bit saw_cout);
        logic [2*W-1:0] exp_p;
        int n;
        exp_p    = (2*W)'(int'(m) * int'(q));
        saw_cout = 1'b0;
        check({name, ".ready_before"}, 32'(ready), 32'd1);
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        step();
        start        = 1'b0;
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
        n = 0;
        while (!done && n < 20) begin
            if (n == 0) begin
                check({name, ".busy_calc"}, 32'({ready, busy}), 32'b01);
                check({name, ".product_held"}, 32'(product), 32'(prev_product));
            end
            if (inject && n == 1) begin
                start        = 1'b1;
                multiplicand = 4'h1;
                multiplier   = 4'h1;
            end else begin
                start = 1'b0;
            end
            saw_cout |= add_cout;
            step();
            n++;
        end
        start = 1'b0;
        check({name, ".latency"}, 32'(n), 32'(W));
        check({name, ".product"}, 32'(product), 32'(exp_p));
        check({name, ".done_flags"}, 32'({done, ready, busy}), 32'b101);
        step();
        check({name, ".after_done"}, 32'({done, ready, busy}), 32'b010);
        check({name, ".product_hold"}, 32'(product), 32'(exp_p));
        prev_product = exp_p;
    endtask

    initial begin
        bit             cout_seen;
        int             extra;
        logic [W-1:0]   rm;
        logic [W-1:0]   rq;

        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        step();
        step();
        rst = 1'b0;
        step();
        check("reset.product", 32'(product), 32'h00);
        check("reset.flags", 32'({ready, busy, done}), 32'b100);
        check("reset.adder", 32'({add_a, add_b}), 32'h00);

        run_op("zero", 4'h0, 4'h9, 1'b0, cout_seen);

        run_op("carry", 4'hF, 4'hF, 1'b0, cout_seen);
        check("carry.cout_seen", 32'(cout_seen), 32'd1);

        run_op("mixed", 4'hD, 4'hB, 1'b0, cout_seen);
        run_op("b2b", 4'h3, 4'h5, 1'b0, cout_seen);

        run_op("ignore", 4'h7, 4'h6, 1'b1, cout_seen);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy || done) extra++;
            step();
        end
        check("ignore.no_second_op", 32'(extra), 32'd0);
        check("ignore.product_kept", 32'(product), 32'h2A);

        // Reset asserted asynchronously after the first step of 0xF*0xF.
        start        = 1'b1;
        multiplicand = 4'hF;
        multiplier   = 4'hF;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("midrst.product", 32'(product), 32'h00);
        check("midrst.flags", 32'({ready, busy, done}), 32'b100);
        check("midrst.adder", 32'({add_a, add_b}), 32'h00);
        step();
        rst = 1'b0;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) extra++;
            step();
        end
        check("midrst.no_done", 32'(extra), 32'd0);
        prev_product = '0;
        run_op("after_rst", 4'h2, 4'h3, 1'b0, cout_seen);

        for (int i = 0; i < 12; i++) begin
            rm = W'($urandom_range(0, 15));
            rq = W'($urandom_range(0, 15));
            run_op($sformatf("rand%0d", i), rm, rq, 1'b0, cout_seen);
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) step();
        end

        run_op("edge_f1", 4'hF, 4'h1, 1'b0, cout_seen);
        run_op("edge_1f", 4'h1, 4'hF, 1'b0, cout_seen);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
